// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM request arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    localparam logic RWN_READ  = 1'b1;
    localparam logic RWN_WRITE = 1'b0;

    // Register map of the FSMC bridge (port 0) that fronts this arbiter
    localparam int unsigned      PERIPH_AW           = 8;
    localparam logic [PERIPH_AW-1:0] PERIPH_REG_CTRL    = 8'h00;
    localparam logic [PERIPH_AW-1:0] PERIPH_REG_STATUS  = 8'h04;
    localparam logic [PERIPH_AW-1:0] PERIPH_REG_ADDR_LO = 8'h08;
    localparam logic [PERIPH_AW-1:0] PERIPH_REG_ADDR_HI = 8'h0C;
    localparam logic [PERIPH_AW-1:0] PERIPH_REG_WDATA   = 8'h10;
    localparam logic [PERIPH_AW-1:0] PERIPH_REG_RDATA   = 8'h14;

    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Request/response bus of both ports plus the controller-facing signals.
interface sdram_arbiter_if #(
    parameter int unsigned ADRW = 27,
    parameter int unsigned DATW = 16
);
    logic [1:0]      req_valid;
    logic [1:0]      req_write;
    logic [ADRW-1:0] req_addr0;
    logic [ADRW-1:0] req_addr1;
    logic [DATW-1:0] req_wdata0;
    logic [DATW-1:0] req_wdata1;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic            rsp_err;
    logic [DATW-1:0] rsp_rdata;
    logic            sd_init_done;
    logic            sd_busy;
    logic            sd_data_valid;
    logic            sd_write_done;
    logic [DATW-1:0] sd_rdata;
    logic            sd_adv;
    logic            sd_rwn;
    logic [ADRW-1:0] sd_addr;
    logic [DATW-1:0] sd_wdata;

    modport slave (
        input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  sd_init_done, sd_busy, sd_data_valid, sd_write_done, sd_rdata,
        output sd_adv, sd_rwn, sd_addr, sd_wdata
    );

    modport master (
        output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        output sd_init_done, sd_busy, sd_data_valid, sd_write_done, sd_rdata,
        input  sd_adv, sd_rwn, sd_addr, sd_wdata
    );
endinterface

// File: rtl/sdram_rr_grant.sv
// Two-input round-robin grant; r_last remembers the most recently granted port.
module sdram_rr_grant
    import sdram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt_c,
    output logic       o_idx_c
);
    logic r_last;
    logic w_any;

    assign w_any   = i_en & (|i_req);
    assign o_idx_c = (i_req == 2'b11) ? ~r_last : i_req[1];
    assign o_gnt_c = w_any ? port_onehot(o_idx_c) : 2'b00;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_last <= 1'b1;
        end else if (w_any) begin
            r_last <= o_idx_c;
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller between two single-word request ports,
// issuing one i_adv per request and returning data/completion or a timeout.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADRW = 27,
    parameter int unsigned DATW = 16,
    parameter int unsigned TMO  = 1023
) (
    input logic            clk,
    input logic            nrst,
    sdram_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TMO + 1);

    arb_state_t      r_state,     w_state_nxt;
    logic            r_owner,     w_owner_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic            r_sd_adv,    w_sd_adv_nxt;
    logic            r_sd_rwn,    w_sd_rwn_nxt;
    logic [ADRW-1:0] r_sd_addr,   w_sd_addr_nxt;
    logic [DATW-1:0] r_sd_wdata,  w_sd_wdata_nxt;
    logic [1:0]      r_rsp_valid, w_rsp_valid_nxt;
    logic            r_rsp_err,   w_rsp_err_nxt;
    logic [DATW-1:0] r_rsp_rdata, w_rsp_rdata_nxt;

    logic            w_sd_idle;
    logic            w_arb_en;
    logic [1:0]      w_gnt;
    logic            w_gnt_idx;
    logic            w_done;

    assign w_sd_idle = bus.sd_init_done & ~bus.sd_busy;
    // nrst gates the grant so req_ready drops the instant reset asserts
    assign w_arb_en  = (r_state == IDLE) & nrst;

    sdram_rr_grant u_grant (
        .clk     (clk),
        .nrst    (nrst),
        .i_en    (w_arb_en),
        .i_req   (bus.req_valid),
        .o_gnt_c (w_gnt),
        .o_idx_c (w_gnt_idx)
    );

    assign bus.req_ready = w_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.sd_adv    = r_sd_adv;
    assign bus.sd_rwn    = r_sd_rwn;
    assign bus.sd_addr   = r_sd_addr;
    assign bus.sd_wdata  = r_sd_wdata;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_cnt       <= '0;
            r_sd_adv    <= 1'b0;
            r_sd_rwn    <= RWN_READ;
            r_sd_addr   <= '0;
            r_sd_wdata  <= '0;
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sd_adv    <= w_sd_adv_nxt;
            r_sd_rwn    <= w_sd_rwn_nxt;
            r_sd_addr   <= w_sd_addr_nxt;
            r_sd_wdata  <= w_sd_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_cnt_nxt       = r_cnt;
        w_sd_adv_nxt    = 1'b0;
        w_sd_rwn_nxt    = r_sd_rwn;
        w_sd_addr_nxt   = r_sd_addr;
        w_sd_wdata_nxt  = r_sd_wdata;
        w_rsp_valid_nxt = 2'b00;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_done          = 1'b0;

        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    w_owner_nxt    = w_gnt_idx;
                    w_sd_rwn_nxt   = bus.req_write[w_gnt_idx] ? RWN_WRITE : RWN_READ;
                    w_sd_addr_nxt  = w_gnt_idx ? bus.req_addr1  : bus.req_addr0;
                    w_sd_wdata_nxt = w_gnt_idx ? bus.req_wdata1 : bus.req_wdata0;
                    w_state_nxt    = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (w_sd_idle) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_sd_adv_nxt = 1'b1;
                w_cnt_nxt    = '0;
                w_state_nxt  = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Only the strobe matching the latched operation completes it
                w_done = (r_sd_rwn == RWN_READ) ? bus.sd_data_valid : bus.sd_write_done;
                if (w_done) begin
                    w_rsp_valid_nxt = port_onehot(r_owner);
                    if (r_sd_rwn == RWN_READ) begin
                        w_rsp_rdata_nxt = bus.sd_rdata;
                    end
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_W'(TMO)) begin
                    w_rsp_valid_nxt = port_onehot(r_owner);
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_state_nxt     = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and randomized transactions against a transaction-level model of
// arbitration order, issue latency, completion/timeout latency and response data.
module tb_sdram_arbiter;
    localparam int unsigned ADRW = 27;
    localparam int unsigned DATW = 16;
    localparam int unsigned TMO  = 15;

    logic clk;
    logic nrst;
    int   checks;
    int   failures;

    sdram_arbiter_if #(.ADRW(ADRW), .DATW(DATW)) bus ();

    sdram_arbiter #(.ADRW(ADRW), .DATW(DATW), .TMO(TMO)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: round-robin history and last response data
    logic            m_last;
    logic [DATW-1:0] m_rdata;
    bit              t_write [2];
    logic [ADRW-1:0] t_addr  [2];
    logic [DATW-1:0] t_wdata [2];
    int              rsp_cnt [2];
    logic [3:0]      seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int p);
        t_write[p] = ($urandom_range(1, 0) == 1);
        t_addr[p]  = ADRW'($urandom);
        t_wdata[p] = DATW'($urandom);
    endtask

    task automatic drive_req(input logic [1:0] vmask);
        bus.req_valid  = vmask;
        bus.req_write  = {t_write[1], t_write[0]};
        bus.req_addr0  = t_addr[0];
        bus.req_addr1  = t_addr[1];
        bus.req_wdata0 = t_wdata[0];
        bus.req_wdata1 = t_wdata[1];
    endtask

    // One request from accept to response; d<0 means the controller never answers
    task automatic run_txn(input logic [1:0] vmask, input int stall, input bit stall_init,
                           input int d, input bit early, input logic [DATW-1:0] rd);
        logic       g;
        logic [1:0] gm;
        int         a_off;
        int         rj;
        g  = (vmask == 2'b11) ? ~m_last : vmask[1];
        gm = g ? 2'b10 : 2'b01;
        drive_req(vmask);
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(gm));
        seq = {seq[2:0], bus.req_ready[1]};
        tick();
        m_last = g;
        bus.req_valid = vmask & ~gm;
        if (g) begin
            bus.req_addr1  = ADRW'($urandom);
            bus.req_wdata1 = DATW'($urandom);
        end else begin
            bus.req_addr0  = ADRW'($urandom);
            bus.req_wdata0 = DATW'($urandom);
        end
        chk("ready_after_accept", 32'(bus.req_ready), 32'd0);
        chk("rsp_single_pulse", 32'(bus.rsp_valid), 32'd0);
        chk("sd_rwn", 32'(bus.sd_rwn), t_write[g] ? 32'd0 : 32'd1);
        chk("sd_addr", 32'(bus.sd_addr), 32'(t_addr[g]));
        chk("sd_wdata", 32'(bus.sd_wdata), 32'(t_wdata[g]));
        a_off = stall + 2;
        for (int off = 0; off < a_off; off++) begin
            chk("adv_early", 32'(bus.sd_adv), 32'd0);
            bus.sd_busy       = (off < stall) && !stall_init;
            bus.sd_init_done  = !((off < stall) && stall_init);
            bus.sd_data_valid = early && (off == stall + 1) && !t_write[g];
            bus.sd_write_done = early && (off == stall + 1) && t_write[g];
            tick();
        end
        bus.sd_data_valid = 1'b0;
        bus.sd_write_done = 1'b0;
        chk("adv_pulse", 32'(bus.sd_adv), 32'd1);
        chk("adv_addr", 32'(bus.sd_addr), 32'(t_addr[g]));
        rj = (d >= 0) ? d + 1 : int'(TMO) + 1;
        for (int j = 0; j < rj; j++) begin
            if (j > 0) chk("adv_once", 32'(bus.sd_adv), 32'd0);
            chk("rsp_wait", 32'(bus.rsp_valid), 32'd0);
            bus.sd_rdata      = (j == d) ? rd : DATW'($urandom);
            bus.sd_data_valid = (j == d) ? !t_write[g] : (t_write[g] && $urandom_range(1, 0) == 1);
            bus.sd_write_done = (j == d) ? t_write[g] : (!t_write[g] && $urandom_range(1, 0) == 1);
            tick();
        end
        bus.sd_data_valid = 1'b0;
        bus.sd_write_done = 1'b0;
        if (d < 0) m_rdata = '0;
        else if (!t_write[g]) m_rdata = rd;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(gm));
        chk("rsp_err", 32'(bus.rsp_err), (d < 0) ? 32'd1 : 32'd0);
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
        if (bus.rsp_valid[0]) rsp_cnt[0]++;
        if (bus.rsp_valid[1]) rsp_cnt[1]++;
    endtask

    initial begin
        logic [1:0] vm;
        int         dd;
        checks   = 0;
        failures = 0;
        m_last   = 1'b1;
        m_rdata  = '0;
        seq      = 4'b0000;
        rsp_cnt[0] = 0;
        rsp_cnt[1] = 0;
        nrst = 1'b1;
        bus.req_valid = 2'b00; bus.req_write = 2'b00;
        bus.req_addr0 = '0; bus.req_addr1 = '0; bus.req_wdata0 = '0; bus.req_wdata1 = '0;
        bus.sd_init_done = 1'b0; bus.sd_busy = 1'b0;
        bus.sd_data_valid = 1'b0; bus.sd_write_done = 1'b0; bus.sd_rdata = '0;
        for (int p = 0; p < 2; p++) new_req(p);

        #2 nrst = 1'b0;
        #1;
        chk("reset_adv", 32'(bus.sd_adv), 32'd0);
        chk("reset_rwn", 32'(bus.sd_rwn), 32'd1);
        chk("reset_addr", 32'(bus.sd_addr), 32'd0);
        chk("reset_wdata", 32'(bus.sd_wdata), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("reset_ready", 32'(bus.req_ready), 32'd0);
        tick();
        tick();
        nrst = 1'b1;
        bus.sd_init_done = 1'b1;
        tick();

        // Port 0 write, then port 1 read at the top address
        t_write[0] = 1'b1; t_addr[0] = 27'h0000123; t_wdata[0] = 16'hBEEF;
        run_txn(2'b01, 0, 1'b0, 3, 1'b0, 16'h0000);
        t_write[1] = 1'b0; t_addr[1] = 27'h7FFFFFF; t_wdata[1] = 16'h0000;
        run_txn(2'b10, 0, 1'b0, 6, 1'b0, 16'h5A5A);

        // Both ports continuously valid: grants alternate starting at port 0
        rsp_cnt[0] = 0; rsp_cnt[1] = 0; seq = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            run_txn(2'b11, 0, 1'b0, int'($urandom_range(5, 0)), 1'b0, DATW'($urandom));
            new_req(bus.req_valid[0] ? 1 : 0);
        end
        chk("rr_sequence", 32'(seq), 32'h5);
        chk("rr_port0_rsps", 32'(rsp_cnt[0]), 32'd2);
        chk("rr_port1_rsps", 32'(rsp_cnt[1]), 32'd2);

        // Stalls: controller busy for 20 cycles, then init_done low for 5
        run_txn(2'b01, 20, 1'b0, 2, 1'b0, DATW'($urandom));
        new_req(0);
        run_txn(2'b01, 5, 1'b1, 4, 1'b0, DATW'($urandom));

        // Timeouts on a read and a write, completion at the last legal cycle, early strobes
        t_write[1] = 1'b0; new_req(0); t_write[0] = 1'b1;
        bus.sd_rdata = 16'hFFFF;
        run_txn(2'b10, 0, 1'b0, -1, 1'b0, 16'h0000);
        run_txn(2'b01, 1, 1'b0, -1, 1'b0, 16'h0000);
        t_write[1] = 1'b0;
        run_txn(2'b10, 0, 1'b0, int'(TMO), 1'b0, 16'hC3A5);
        t_write[0] = 1'b1;
        run_txn(2'b01, 0, 1'b0, 0, 1'b1, 16'h1111);
        t_write[1] = 1'b0;
        run_txn(2'b10, 2, 1'b0, 2, 1'b1, 16'h2222);

        // Randomized mix; ports keep their request until it is accepted
        for (int k = 0; k < 14; k++) begin
            for (int p = 0; p < 2; p++) if (!bus.req_valid[p]) new_req(p);
            vm = bus.req_valid | 2'($urandom_range(3, 0));
            if (vm == 2'b00) vm = 2'b01;
            dd = ($urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(15, 0));
            run_txn(vm, int'($urandom_range(4, 0)), ($urandom_range(1, 0) == 1), dd,
                    ($urandom_range(1, 0) == 1), DATW'($urandom));
        end
        if (bus.req_valid != 2'b00) run_txn(bus.req_valid, 0, 1'b0, 1, 1'b0, DATW'($urandom));

        // Reset while waiting for completion drops the request
        t_write[0] = 1'b0; t_addr[0] = 27'h0ABCDEF;
        drive_req(2'b01);
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        chk("adv_before_reset", 32'(bus.sd_adv), 32'd1);
        bus.req_valid = 2'b11;
        #2 nrst = 1'b0;
        #1;
        chk("midrst_adv", 32'(bus.sd_adv), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_ready", 32'(bus.req_ready), 32'd0);
        chk("midrst_rwn", 32'(bus.sd_rwn), 32'd1);
        chk("midrst_addr", 32'(bus.sd_addr), 32'd0);
        chk("midrst_rdata", 32'(bus.rsp_rdata), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 nrst = 1'b1;
        m_last  = 1'b1;
        m_rdata = '0;
        new_req(0); new_req(1);
        run_txn(2'b11, 0, 1'b0, 3, 1'b0, DATW'($urandom));
        run_txn(bus.req_valid, 0, 1'b0, 1, 1'b0, DATW'($urandom));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
